gshare_spec_predictor: RTL and testbench
========================================

Name: gshare_spec_predictor

Overview:
- Next-generation gshare branch predictor for the 5-stage pipeline.
- The fetch stage reads the direct-mapped BTB and the PHT combinationally; the commit stage (EX/MEM) writes both back.
- Adds speculative global history updated at fetch with checkpoint repair on mispredict, and parametrised saturating-counter width.
- Adds a post-reset PHT init sweep (SRAM-friendly) and saturating performance counters.

Parameters:
- INDEX_WIDTH, 6, log2 of BTB entries; tag width is 30-INDEX_WIDTH.
- HISTORY_WIDTH, 8, GHR length; PHT has 2^HISTORY_WIDTH entries.
- CTR_WIDTH, 2, PHT counter width, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ready_o  out  1  high once the PHT init sweep is complete
- IF_valid_i  in  1  fetch slot valid
- IF_pc_i  in  32  fetch PC
- IF_btb_hit_o  out  1  BTB tag match and entry valid
- IF_prediction_o  out  1  predict taken
- IF_target_o  out  32  BTB target
- IF_ghr_o  out  HISTORY_WIDTH  speculative GHR used for this lookup (checkpoint carried down the pipe)
- EX_valid_i  in  1  resolved control instruction valid
- EX_pc_i  in  32  PC of the resolved instruction
- EX_is_br_i  in  1  conditional branch
- EX_is_jmp_i  in  1  JAL/JALR
- EX_taken_i  in  1  actual outcome
- EX_target_i  in  32  actual target
- EX_btb_hit_i  in  1  fetch-time BTB hit
- EX_mispredict_i  in  1  direction or target mispredict; pipeline flushes younger instructions
- EX_ghr_i  in  HISTORY_WIDTH  checkpoint captured from IF_ghr_o
- br_cnt_o  out  32  resolved control instruction count
- mispred_cnt_o  out  32  mispredict count

Behaviour:
- Indexing:
  - BTB index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2].
  - PHT index = pc[HISTORY_WIDTH+1:2] XOR ghr.
- Reads are combinational; all writes occur on posedge clk_i.
- Same-cycle read and write to the same entry: the read returns the old value (no bypass).
- BTB entry = {valid, tag, target, is_cond}.
- Prediction = hit & (!is_cond | counter MSB), so jumps that hit are always predicted taken.
- IF_target_o is the entry target regardless of hit.
- FSM states INIT and RUN:
  - rst_i forces INIT and sets init_idx=0.
  - INIT writes the weakly-not-taken value (2^(CTR_WIDTH-1)-1) to PHT[init_idx] each cycle and increments init_idx.
  - After entry 2^HISTORY_WIDTH-1 is written, the FSM moves to RUN and ready_o rises the next cycle.
  - The sweep takes exactly 2^HISTORY_WIDTH cycles after reset release.
  - In INIT: ready_o=0, IF_btb_hit_o=0, IF_prediction_o=0, and all EX inputs are ignored.
- Reset values:
  - All BTB valid bits 0, applied in the reset cycle.
  - spec_ghr=0, counters 0, ready_o=0.
  - IF_target_o is don't-care.
  - Reset asserted mid-operation restarts INIT from index 0.
- Speculative GHR:
  - In RUN, when IF_valid_i & IF_btb_hit_o & is_cond, spec_ghr <= {spec_ghr[H-2:0], IF_prediction_o}.
  - Jumps and BTB misses do not shift the history.
- Recovery (RUN, EX_valid_i & EX_mispredict_i) takes priority over a same-cycle fetch shift:
  - If EX_is_br_i & EX_btb_hit_i: spec_ghr <= {EX_ghr_i[H-2:0], EX_taken_i}.
  - Otherwise: spec_ghr <= EX_ghr_i.
- PHT update:
  - Applies on EX_valid_i & EX_is_br_i, at index EX_pc XOR EX_ghr_i.
  - Taken increments and not-taken decrements, saturating at 0 and 2^CTR_WIDTH-1.
  - Jumps never touch the PHT.
- BTB write:
  - Applies on EX_valid_i & (EX_is_br_i | EX_is_jmp_i) & EX_taken_i.
  - Writes valid=1, tag, target=EX_target_i, is_cond=EX_is_br_i.
  - This overwrites on hit (target refresh) or alias.
  - Not-taken branches never allocate an entry.
- EX_is_br_i and EX_is_jmp_i both high is illegal; the bench asserts against it.
- Performance counters:
  - br_cnt_o increments on EX_valid_i & (br|jmp) in RUN.
  - mispred_cnt_o increments when EX_mispredict_i is also high.
  - Both saturate at 32'hFFFF_FFFF.

Decomposition:
- Package bp_pkg contains:
  - typedef btb_entry_t
  - enum bp_state_e {INIT, RUN}
  - function sat_update(ctr, taken)
  - constant weak-not-taken value
- Sub-module pht_ctr_table holds the counter array, one read port, one write port, and an init-write mux.
- BTB storage and the GHR stay inline.

Test Plan:
- Reset then idle with HISTORY_WIDTH=8 -> ready_o low for exactly 256 cycles, then high; IF_prediction_o=0 throughout INIT.
- Resolve taken JAL at PC 0x100, target 0x400 -> next fetch of 0x100 gives hit=1, prediction=1, target=0x400; PHT unchanged; spec_ghr unchanged.
- Conditional branch at 0x200 resolved taken 3x with the same checkpoint -> counter saturates at 3; a 4th taken update leaves it at 3; fetch with that history predicts taken.
- Fetch hits cond branch (spec_ghr 0x0F -> 0x1F), then EX mispredict with EX_ghr_i=0x0F, taken=0, btb_hit=1, same cycle as another fetch shift -> spec_ghr=0x1E; the fetch shift is dropped.
- Not-taken branch with BTB miss -> no BTB allocation; PHT updated; br_cnt_o+1, mispred_cnt_o unchanged.
- Preload mispred_cnt_o to saturation (force) plus one mispredict -> stays 0xFFFF_FFFF; assert rst_i mid-sweep -> sweep restarts at index 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare speculative predictor.
//   btb_entry_t : one direct-mapped BTB line {valid, tag, target, is_cond}
//   bp_state_e  : INIT (PHT sweep) / RUN
//   weak_nt()   : weakly-not-taken counter value for a given counter width
//   sat_update(): saturating up/down counter step
package bp_pkg;

  // Widest counter and tag the helpers/struct can hold. Narrower instances
  // zero-extend into these fields.
  localparam int CTR_W_MAX = 8;
  localparam int TAG_W_MAX = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;     // pc[31:INDEX_WIDTH+2], zero-extended
    logic [31:0]          target;
    logic                 is_cond;
  } btb_entry_t;

  typedef enum logic {INIT, RUN} bp_state_e;

  function automatic logic [CTR_W_MAX-1:0] weak_nt(input int unsigned w);
    return CTR_W_MAX'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  // Weakly-not-taken value for the default 2-bit counter.
  localparam logic [CTR_W_MAX-1:0] WEAK_NT_2B = CTR_W_MAX'(1);

  function automatic logic [CTR_W_MAX-1:0] sat_update(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input logic [CTR_W_MAX-1:0] ctr_max
  );
    if (taken) return (ctr == ctr_max) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)      ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/pht_ctr_table.sv
// Pattern history table of saturating counters.
//   gclk               : clock
//   init_en/init_idx   : sweep write of the weakly-not-taken value (wins)
//   upd_en/upd_idx/upd_taken : saturating read-modify-write from commit
//   rd_idx/rd_ctr      : combinational fetch read, no write bypass
module pht_ctr_table
  import bp_pkg::*;
#(
  parameter int HISTORY_WIDTH = 8,
  parameter int CTR_WIDTH     = 2
) (
  input  logic                     gclk,
  input  logic                     init_en,
  input  logic [HISTORY_WIDTH-1:0] init_idx,
  input  logic                     upd_en,
  input  logic [HISTORY_WIDTH-1:0] upd_idx,
  input  logic                     upd_taken,
  input  logic [HISTORY_WIDTH-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0]     rd_ctr
);

  localparam logic [CTR_WIDTH-1:0] WNT  = CTR_WIDTH'(weak_nt(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] CMAX = '1;

  logic [CTR_WIDTH-1:0] tbl [2**HISTORY_WIDTH];

  // Single write port: the sweep owns it during INIT, commit otherwise.
  always_ff @(posedge gclk) begin
    if (init_en)
      tbl[init_idx] <= WNT;
    else if (upd_en)
      tbl[upd_idx] <= CTR_WIDTH'(sat_update(CTR_W_MAX'(tbl[upd_idx]), upd_taken,
                                            CTR_W_MAX'(CMAX)));
  end

  assign rd_ctr = tbl[rd_idx];

endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare branch predictor with speculative global history.
//   clk_i/rst_i : clock, synchronous active-high reset
//   ready_o     : PHT init sweep complete
//   IF_*        : combinational fetch lookup (BTB + PHT), GHR checkpoint out
//   EX_*        : commit-time update, mispredict recovery via checkpoint
//   br_cnt_o / mispred_cnt_o : saturating performance counters
module gshare_spec_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8,
  parameter int CTR_WIDTH     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic                     IF_valid_i,
  input  logic [31:0]              IF_pc_i,
  output logic                     IF_btb_hit_o,
  output logic                     IF_prediction_o,
  output logic [31:0]              IF_target_o,
  output logic [HISTORY_WIDTH-1:0] IF_ghr_o,
  input  logic                     EX_valid_i,
  input  logic [31:0]              EX_pc_i,
  input  logic                     EX_is_br_i,
  input  logic                     EX_is_jmp_i,
  input  logic                     EX_taken_i,
  input  logic [31:0]              EX_target_i,
  input  logic                     EX_btb_hit_i,
  input  logic                     EX_mispredict_i,
  input  logic [HISTORY_WIDTH-1:0] EX_ghr_i,
  output logic [31:0]              br_cnt_o,
  output logic [31:0]              mispred_cnt_o
);

  localparam int BTB_N = 2**INDEX_WIDTH;
  localparam int HW    = HISTORY_WIDTH;

  // ---------------- INIT/RUN FSM ----------------
  bp_state_e       state, state_nxt;
  logic [HW-1:0]   init_idx;
  logic            run;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_idx == '1) state_nxt = RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)               init_idx <= '0;
    else if (state == INIT)  init_idx <= init_idx + 1'b1;
  end

  assign run     = (state == RUN);
  assign ready_o = run;

  // ---------------- BTB ----------------
  btb_entry_t                 btb [BTB_N];
  btb_entry_t                 if_ent;
  logic [INDEX_WIDTH-1:0]     if_bidx, ex_bidx;
  logic [TAG_W_MAX-1:0]       if_tag, ex_tag;
  logic                       btb_wr;

  assign if_bidx = IF_pc_i[INDEX_WIDTH+1:2];
  assign ex_bidx = EX_pc_i[INDEX_WIDTH+1:2];
  assign if_tag  = TAG_W_MAX'(IF_pc_i[31:INDEX_WIDTH+2]);
  assign ex_tag  = TAG_W_MAX'(EX_pc_i[31:INDEX_WIDTH+2]);
  assign if_ent  = btb[if_bidx];

  // Only taken control flow allocates; a not-taken branch stays invisible
  // to fetch and falls through naturally.
  assign btb_wr = run && EX_valid_i && (EX_is_br_i || EX_is_jmp_i) && EX_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_N; i++) btb[i].valid <= 1'b0;
    end else if (btb_wr) begin
      btb[ex_bidx] <= '{valid: 1'b1, tag: ex_tag, target: EX_target_i,
                        is_cond: EX_is_br_i};
    end
  end

  // ---------------- PHT ----------------
  logic [HW-1:0]        spec_ghr;
  logic [CTR_WIDTH-1:0] pht_ctr;

  pht_ctr_table #(.HISTORY_WIDTH(HW), .CTR_WIDTH(CTR_WIDTH)) u_pht (
    .gclk      (clk_i),
    .init_en   (state == INIT && !rst_i),
    .init_idx  (init_idx),
    .upd_en    (run && EX_valid_i && EX_is_br_i),
    .upd_idx   (EX_pc_i[HW+1:2] ^ EX_ghr_i),
    .upd_taken (EX_taken_i),
    .rd_idx    (IF_pc_i[HW+1:2] ^ spec_ghr),
    .rd_ctr    (pht_ctr)
  );

  // ---------------- Fetch outputs ----------------
  assign IF_btb_hit_o    = run && if_ent.valid && (if_ent.tag == if_tag);
  assign IF_prediction_o = IF_btb_hit_o && (!if_ent.is_cond || pht_ctr[CTR_WIDTH-1]);
  assign IF_target_o     = if_ent.target;
  assign IF_ghr_o        = spec_ghr;

  // ---------------- Speculative GHR ----------------
  // Recovery beats the fetch shift: the fetch being shifted is on the
  // wrong path and is flushed along with everything younger.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_ghr <= '0;
    end else if (run) begin
      if (EX_valid_i && EX_mispredict_i)
        spec_ghr <= (EX_is_br_i && EX_btb_hit_i) ? {EX_ghr_i[HW-2:0], EX_taken_i}
                                                 : EX_ghr_i;
      else if (IF_valid_i && IF_btb_hit_o && if_ent.is_cond)
        spec_ghr <= {spec_ghr[HW-2:0], IF_prediction_o};
    end
  end

  // ---------------- Performance counters ----------------
  logic [31:0] br_cnt_q, mispred_cnt_q;
  logic        cnt_ev;

  assign cnt_ev = run && EX_valid_i && (EX_is_br_i || EX_is_jmp_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (cnt_ev && br_cnt_q != '1)                         br_cnt_q      <= br_cnt_q + 1'b1;
      if (cnt_ev && EX_mispredict_i && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // Instructions are word aligned; the low PC bits carry no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{IF_pc_i[1:0], EX_pc_i[1:0]};

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Self-checking bench for gshare_spec_predictor (default parameters).
module tb_gshare_spec_predictor;

  logic        clk, rst;
  logic        ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_hit, if_pred;
  logic [31:0] if_tgt;
  logic [7:0]  if_ghr;
  logic        ex_valid, ex_br, ex_jmp, ex_tk, ex_bh, ex_mis;
  logic [31:0] ex_pc, ex_tgt;
  logic [7:0]  ex_ghr;
  logic [31:0] br_cnt, mis_cnt;

  int checks   = 0;
  int failures = 0;

  gshare_spec_predictor dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .IF_valid_i(if_valid), .IF_pc_i(if_pc), .IF_btb_hit_o(if_hit),
    .IF_prediction_o(if_pred), .IF_target_o(if_tgt), .IF_ghr_o(if_ghr),
    .EX_valid_i(ex_valid), .EX_pc_i(ex_pc), .EX_is_br_i(ex_br),
    .EX_is_jmp_i(ex_jmp), .EX_taken_i(ex_tk), .EX_target_i(ex_tgt),
    .EX_btb_hit_i(ex_bh), .EX_mispredict_i(ex_mis), .EX_ghr_i(ex_ghr),
    .br_cnt_o(br_cnt), .mispred_cnt_o(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && ex_valid) assert (!(ex_br && ex_jmp)) else $error("illegal br+jmp stimulus");

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    string       nm;
    bit          if_v;  logic [31:0] if_pc;
    bit          ex_v;  logic [31:0] ex_pc;
    bit          br, jmp, tk; logic [31:0] tgt; bit ebh, mis; logic [7:0] eghr;
    bit          chk_if, e_hit, e_pred; logic [31:0] e_tgt; logic [7:0] e_ghr;
    logic [7:0]  n_ghr; logic [31:0] n_br, n_mis;
  } vec_t;

  typedef struct {
    string nm; logic [7:0] ghr; logic [31:0] br, mis;
  } post_t;

  vec_t  tbl[$];
  post_t sbq[$];

  function automatic vec_t mk(string nm, bit if_v, logic [31:0] ipc,
      bit ex_v, logic [31:0] epc, bit br, bit jmp, bit tk, logic [31:0] tgt,
      bit ebh, bit mis, logic [7:0] eghr,
      bit chk_if, bit e_hit, bit e_pred, logic [31:0] e_tgt, logic [7:0] e_ghr,
      logic [7:0] n_ghr, logic [31:0] n_br, logic [31:0] n_mis);
    vec_t v;
    v.nm = nm; v.if_v = if_v; v.if_pc = ipc; v.ex_v = ex_v; v.ex_pc = epc;
    v.br = br; v.jmp = jmp; v.tk = tk; v.tgt = tgt; v.ebh = ebh; v.mis = mis;
    v.eghr = eghr; v.chk_if = chk_if; v.e_hit = e_hit; v.e_pred = e_pred;
    v.e_tgt = e_tgt; v.e_ghr = e_ghr; v.n_ghr = n_ghr; v.n_br = n_br; v.n_mis = n_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_pc = '0;
    ex_valid = 0; ex_pc = '0; ex_br = 0; ex_jmp = 0; ex_tk = 0;
    ex_tgt = '0; ex_bh = 0; ex_mis = 0; ex_ghr = '0;
  endtask

  task automatic apply(input vec_t t);
    post_t p;
    @(negedge clk);
    if_valid = t.if_v; if_pc = t.if_pc;
    ex_valid = t.ex_v; ex_pc = t.ex_pc; ex_br = t.br; ex_jmp = t.jmp;
    ex_tk = t.tk; ex_tgt = t.tgt; ex_bh = t.ebh; ex_mis = t.mis; ex_ghr = t.eghr;
    #1;
    if (t.chk_if) begin
      chk({t.nm, ":hit"},  32'(if_hit),  32'(t.e_hit));
      chk({t.nm, ":pred"}, 32'(if_pred), 32'(t.e_pred));
      if (t.e_hit) chk({t.nm, ":target"}, if_tgt, t.e_tgt);
      chk({t.nm, ":ghr_in"}, 32'(if_ghr), 32'(t.e_ghr));
    end
    sbq.push_back(post_t'{t.nm, t.n_ghr, t.n_br, t.n_mis});
    @(posedge clk); #1;
    idle_inputs();
    p = sbq.pop_front();
    chk({p.nm, ":ghr"},     32'(if_ghr), 32'(p.ghr));
    chk({p.nm, ":br_cnt"},  br_cnt,      p.br);
    chk({p.nm, ":mis_cnt"}, mis_cnt,     p.mis);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  // Counts cycles with ready low after reset release (bounded).
  task automatic sweep(input string nm);
    int n, bad;
    n = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (if_hit || if_pred) bad++;
    end
    chk({nm, ":init_cycles"}, 32'(n), 32'd256);
    chk({nm, ":init_quiet"},  32'(bad), 32'd0);
    chk({nm, ":ready"},       32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);

    // ---- reset, sweep with garbage EX/IF traffic that must be ignored ----
    do_reset();
    chk("reset:ready",   32'(ready),   32'd0);
    chk("reset:ghr",     32'(if_ghr),  32'd0);
    chk("reset:br_cnt",  br_cnt,       32'd0);
    chk("reset:mis_cnt", mis_cnt,      32'd0);
    if_valid = 1; if_pc = 32'h7C4;
    ex_valid = 1; ex_pc = 32'h7C4; ex_jmp = 1; ex_tk = 1; ex_tgt = 32'hDEAD0;
    ex_mis = 1; ex_ghr = 8'hAA;
    sweep("sweep1");
    idle_inputs();

    //          name              ifv ifpc         exv expc        br jmp tk tgt           ebh mis eghr   chk hit pred etgt         eghr   nghr   nbr  nmis
    tbl.push_back(mk("init_ignored", 1, 32'h7C4,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 0, 32'h0,       8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("jal_resolve",  0, 32'h0,     1, 32'h100,     0, 1, 1, 32'h400,      0, 0, 8'h00, 0, 0, 0, 32'h0,       8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("jal_fetch",    1, 32'h100,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 1, 32'h400,     8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("ghr_to_0f",    0, 32'h0,     1, 32'h0,       0, 0, 0, 32'h0,        0, 1, 8'h0F, 0, 0, 0, 32'h0,       8'h00, 8'h0F, 1, 0));
    tbl.push_back(mk("br_tk1",       0, 32'h200,   1, 32'h200,     1, 0, 1, 32'h280,      0, 0, 8'h0F, 1, 0, 0, 32'h0,       8'h0F, 8'h0F, 2, 0));
    tbl.push_back(mk("br_tk2",       0, 32'h200,   1, 32'h200,     1, 0, 1, 32'h280,      1, 0, 8'h0F, 1, 1, 1, 32'h280,     8'h0F, 8'h0F, 3, 0));
    tbl.push_back(mk("br_tk3",       0, 32'h0,     1, 32'h200,     1, 0, 1, 32'h280,      1, 0, 8'h0F, 0, 0, 0, 32'h0,       8'h00, 8'h0F, 4, 0));
    tbl.push_back(mk("br_tk4_sat",   0, 32'h0,     1, 32'h200,     1, 0, 1, 32'h280,      1, 0, 8'h0F, 0, 0, 0, 32'h0,       8'h00, 8'h0F, 5, 0));
    tbl.push_back(mk("alias_evict",  1, 32'h100,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 0, 32'h0,       8'h0F, 8'h0F, 5, 0));
    tbl.push_back(mk("cond_shift",   1, 32'h200,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 1, 32'h280,     8'h0F, 8'h1F, 5, 0));
    tbl.push_back(mk("recover_prio", 1, 32'h200,   1, 32'h200,     1, 0, 0, 32'h204,      1, 1, 8'h0F, 1, 1, 0, 32'h280,     8'h1F, 8'h1E, 6, 1));
    tbl.push_back(mk("ghr_back_0f",  0, 32'h0,     1, 32'h0,       0, 0, 0, 32'h0,        0, 1, 8'h0F, 0, 0, 0, 32'h0,       8'h00, 8'h0F, 6, 1));
    tbl.push_back(mk("sat_hi",       0, 32'h200,   1, 32'h200,     1, 0, 0, 32'h204,      1, 0, 8'h0F, 1, 1, 1, 32'h280,     8'h0F, 8'h0F, 7, 1));
    tbl.push_back(mk("sat_lo",       0, 32'h200,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 32'h280,     8'h0F, 8'h0F, 7, 1));
    tbl.push_back(mk("ghr_to_00",    0, 32'h0,     1, 32'h0,       0, 0, 0, 32'h0,        0, 1, 8'h00, 0, 0, 0, 32'h0,       8'h00, 8'h00, 7, 1));
    tbl.push_back(mk("nt_miss",      0, 32'h0,     1, 32'h540,     1, 0, 0, 32'h544,      0, 0, 8'h00, 0, 0, 0, 32'h0,       8'h00, 8'h00, 8, 1));
    tbl.push_back(mk("nt_no_alloc",  0, 32'h540,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 0, 32'h0,       8'h00, 8'h00, 8, 1));
    tbl.push_back(mk("alloc_540",    0, 32'h0,     1, 32'h540,     1, 0, 1, 32'h5A0,      0, 1, 8'h00, 0, 0, 0, 32'h0,       8'h00, 8'h00, 9, 2));
    tbl.push_back(mk("pht_nt_seen",  0, 32'h540,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 32'h5A0,     8'h00, 8'h00, 9, 2));
    tbl.push_back(mk("jmp_recover",  0, 32'h0,     1, 32'h7C4,     0, 1, 1, 32'h800,      1, 1, 8'h33, 0, 0, 0, 32'h0,       8'h00, 8'h33, 10, 3));
    tbl.push_back(mk("jmp_noshift",  1, 32'h7C4,   0, 32'h0,       0, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 1, 32'h800,     8'h33, 8'h33, 10, 3));
    tbl.push_back(mk("br_mis_hit",   0, 32'h0,     1, 32'h200,     1, 0, 1, 32'h280,      1, 1, 8'h33, 0, 0, 0, 32'h0,       8'h00, 8'h67, 11, 4));

    foreach (tbl[i]) apply(tbl[i]);

    // ---- mispredict counter saturation ----
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    apply(mk("mis_sat", 0, 32'h0, 1, 32'h900, 0, 1, 1, 32'h904, 0, 1, 8'h10,
             0, 0, 0, 32'h0, 8'h00, 8'h10, 12, 32'hFFFF_FFFF));

    // ---- reset mid-sweep restarts from index 0 ----
    do_reset();
    repeat (100) @(negedge clk);
    chk("midsweep:ready_low", 32'(ready), 32'd0);
    do_reset();
    sweep("sweep2");
    apply(mk("post_reset_btb", 0, 32'h200, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 8'h00,
             1, 0, 0, 32'h0, 8'h00, 8'h00, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
